matrix_unflatten_stream: RTL and testbench

Sequential inverse of the matrix flattening stage. Accepts one whole matrix per handshake as a packed row-major bit vector, buffers it, and replays it as a row-major stream of DIM1 row beats of DIM0 elements each. Both sides use valid/ready handshakes. The block sits between wide matrix producers (flattened matmul results, parameter loads) and the row-streaming datapath.

---
 rtl/matrix_unflatten_stream.sv | 94 +++++++++
 tb/tb_matrix_unflatten_stream.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_unflatten_stream.sv
// Buffers one packed row-major matrix per input handshake and replays it
// as DIM1 row beats of DIM0 elements, with valid/ready on both sides.
module matrix_unflatten_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM0       = 4,
  parameter int DIM1       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH*DIM0*DIM1-1:0]  data_in,
  input  logic                             data_in_valid,
  output logic                             data_in_ready,
  output logic [DATA_WIDTH-1:0]            data_out [DIM0-1:0],
  output logic                             data_out_valid,
  input  logic                             data_out_ready,
  output logic                             data_out_last
);

  localparam int FLAT_W = DATA_WIDTH * DIM0 * DIM1;
  localparam int ROW_W  = (DIM1 > 1) ? $clog2(DIM1) : 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [FLAT_W-1:0]  r_buf;
  logic [ROW_W-1:0]   r_row;
  logic               w_last_row;
  logic               w_in_hs;
  logic               w_out_hs;

  assign w_last_row = (r_row == ROW_W'(DIM1 - 1));
  assign w_in_hs    = data_in_valid && data_in_ready;
  assign w_out_hs   = data_out_valid && data_out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_EMPTY: if (w_in_hs) w_next_state = S_FULL;
      // A new matrix arriving on the last beat keeps us FULL with no bubble.
      S_FULL:  if (w_out_hs && w_last_row && !w_in_hs) w_next_state = S_EMPTY;
      default: w_next_state = S_EMPTY;
    endcase
  end

  always_comb begin
    data_in_ready  = 1'b0;
    data_out_valid = 1'b0;
    data_out_last  = 1'b0;
    case (r_state)
      S_EMPTY: begin
        data_in_ready = !rst;
      end
      S_FULL: begin
        data_in_ready  = !rst && w_last_row && data_out_ready;
        data_out_valid = 1'b1;
        data_out_last  = w_last_row;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf <= '0;
      r_row <= '0;
    end else begin
      if (w_in_hs) begin
        r_buf <= data_in;
        r_row <= '0;
      end else if (w_out_hs) begin
        r_row <= w_last_row ? '0 : r_row + 1'b1;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < DIM0; c++) begin
      data_out[c] = r_buf[(int'(r_row) * DIM0 + c) * DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: tb/tb_matrix_unflatten_stream.sv
// Bench for matrix_unflatten_stream (8-bit elements, 2x3 matrices): directed
// scenarios plus randomized valid/ready traffic against a row-queue scoreboard.
module tb_matrix_unflatten_stream;
  localparam int DW = 8;
  localparam int D0 = 2;
  localparam int D1 = 3;
  localparam int FW = DW * D0 * D1;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] data_in;
  logic          data_in_valid;
  logic          data_in_ready;
  logic [DW-1:0] data_out [D0-1:0];
  logic          data_out_valid;
  logic          data_out_ready;
  logic          data_out_last;

  matrix_unflatten_stream #(.DATA_WIDTH(DW), .DIM0(D0), .DIM1(D1)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out_last  (data_out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int n_checks   = 0;
  int n_fail     = 0;
  int acc_count  = 0;
  int beats_seen = 0;

  localparam logic [FW-1:0] MAT_A = 48'h050403020100;
  localparam logic [FW-1:0] MAT_B = 48'h151413121110;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: element (r,c) of the accepted matrix sits at flat index r*D0+c.
  task automatic push_matrix(input logic [FW-1:0] m);
    beat_t b;
    for (int r = 0; r < D1; r++) begin
      b.e0   = m[(r * D0 + 0) * DW +: DW];
      b.e1   = m[(r * D0 + 1) * DW +: DW];
      b.last = (r == D1 - 1);
      exp_q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (data_out_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", 64'd1, 64'd0);
        end else begin
          check("sb_row", {data_out[0], data_out[1], data_out_last},
                {exp_q[0].e0, exp_q[0].e1, exp_q[0].last});
          if (data_out_ready) begin
            void'(exp_q.pop_front());
            beats_seen++;
          end
        end
      end
      if (data_in_valid && data_in_ready) begin
        push_matrix(data_in);
        acc_count++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string n, input logic [7:0] e0, input logic [7:0] e1,
                             input logic last);
    check({n, "_valid"}, {63'd0, data_out_valid}, 64'd1);
    check({n, "_data"}, {48'd0, data_out[0], data_out[1]}, {48'd0, e0, e1});
    check({n, "_last"}, {63'd0, data_out_last}, {63'd0, last});
  endtask

  initial begin
    int  sent;
    int  cyc;
    bit  hs;

    rst            = 1'b0;
    data_in        = '0;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, data_out_valid}, 64'd0);
    check("rst_last", {63'd0, data_out_last}, 64'd0);
    check("rst_in_ready", {63'd0, data_in_ready}, 64'd0);
    check("rst_data", {48'd0, data_out[0], data_out[1]}, 64'd0);
    rst = 1'b0;
    #1 check("idle_in_ready", {63'd0, data_in_ready}, 64'd1);

    // Single matrix, ready held high
    data_in = MAT_A; data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    expect_beat("single_r0", 8'h00, 8'h01, 1'b0);
    tick(); expect_beat("single_r1", 8'h02, 8'h03, 1'b0);
    tick(); expect_beat("single_r2", 8'h04, 8'h05, 1'b1);
    tick();
    check("single_done_valid", {63'd0, data_out_valid}, 64'd0);
    check("single_done_ready", {63'd0, data_in_ready}, 64'd1);

    // Back-to-back: B accepted on A's last beat
    data_in = MAT_A; data_in_valid = 1'b1;
    tick();
    data_in = MAT_B;
    expect_beat("b2b_a0", 8'h00, 8'h01, 1'b0);
    check("b2b_blocked", {63'd0, data_in_ready}, 64'd0);
    tick(); expect_beat("b2b_a1", 8'h02, 8'h03, 1'b0);
    tick(); expect_beat("b2b_a2", 8'h04, 8'h05, 1'b1);
    check("b2b_ready_on_last", {63'd0, data_in_ready}, 64'd1);
    tick();
    data_in_valid = 1'b0;
    expect_beat("b2b_b0", 8'h10, 8'h11, 1'b0);
    tick(); expect_beat("b2b_b1", 8'h12, 8'h13, 1'b0);
    tick(); expect_beat("b2b_b2", 8'h14, 8'h15, 1'b1);
    tick();
    check("b2b_done_valid", {63'd0, data_out_valid}, 64'd0);

    // Backpressure on row 1 with B waiting upstream
    data_in = MAT_A; data_in_valid = 1'b1;
    tick();
    data_in = MAT_B;
    expect_beat("bp_a0", 8'h00, 8'h01, 1'b0);
    tick();
    data_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_beat("bp_hold", 8'h02, 8'h03, 1'b0);
      check("bp_in_ready", {63'd0, data_in_ready}, 64'd0);
      tick();
    end
    data_out_ready = 1'b1;
    expect_beat("bp_a1", 8'h02, 8'h03, 1'b0);
    tick(); expect_beat("bp_a2", 8'h04, 8'h05, 1'b1);
    tick();
    data_in_valid = 1'b0;
    expect_beat("bp_b0", 8'h10, 8'h11, 1'b0);
    tick(); expect_beat("bp_b1", 8'h12, 8'h13, 1'b0);
    tick(); expect_beat("bp_b2", 8'h14, 8'h15, 1'b1);
    tick();

    // Reset after row 0 of A has been delivered
    data_in = MAT_A; data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    expect_beat("rm_a0", 8'h00, 8'h01, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    check("rm_valid", {63'd0, data_out_valid}, 64'd0);
    check("rm_in_ready", {63'd0, data_in_ready}, 64'd0);
    check("rm_last", {63'd0, data_out_last}, 64'd0);
    check("rm_data", {48'd0, data_out[0], data_out[1]}, 64'd0);
    tick();
    rst = 1'b0;
    data_in = MAT_B; data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    expect_beat("rm_b0", 8'h10, 8'h11, 1'b0);
    tick(); expect_beat("rm_b1", 8'h12, 8'h13, 1'b0);
    tick(); expect_beat("rm_b2", 8'h14, 8'h15, 1'b1);
    tick();
    acc_count  = 0;
    beats_seen = 0;

    // Randomized valid/ready traffic
    sent = 0;
    cyc  = 0;
    while (sent < 1000) begin
      data_out_ready = ($urandom_range(0, 3) != 0);
      if (!data_in_valid && ($urandom_range(0, 3) != 0)) begin
        data_in[31:0]  = $urandom();
        data_in[47:32] = 16'($urandom());
        data_in_valid  = 1'b1;
      end
      #1 hs = data_in_valid && data_in_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        data_in_valid = 1'b0;
        sent++;
      end
      cyc++;
      if (cyc > 30000) begin
        check("random_cycle_budget", 64'd1, 64'd0);
        break;
      end
    end
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("random_accepted", 64'(acc_count), 64'd1000);
    check("random_beats", 64'(beats_seen), 64'(3 * acc_count));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
